// File: rtl/ps2_key_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_ctrl
// Brief    : Turns PS/2 scan bytes into key events (E0/F0 prefixes, Shift,
//            Caps Lock, repeat suppression) queued in a valid/ready FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_key_ctrl #(
    parameter int DEPTH     = 8,
    parameter int BREAK_EN  = 0,
    parameter int REPEAT_EN = 0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte_data,
    input  logic        i_frame_err,
    output logic        o_ev_valid,
    input  logic        i_ev_ready,
    output logic [10:0] o_ev_data,
    output logic        o_shift,
    output logic        o_caps,
    output logic        o_ovf,
    input  logic        i_ovf_clr,
    output logic [7:0]  o_err_cnt
);

    localparam int c_AW = $clog2(DEPTH);

    localparam logic [1:0] c_IDLE    = 2'b00;
    localparam logic [1:0] c_EXT     = 2'b01;
    localparam logic [1:0] c_BRK     = 2'b10;
    localparam logic [1:0] c_EXT_BRK = 2'b11;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [7:0]      r_held;
    logic            r_shift;
    logic            r_caps;
    logic            r_ovf;
    logic [7:0]      r_err_cnt;
    logic [10:0]     r_mem [DEPTH];
    logic [c_AW:0]   r_wr_ptr;
    logic [c_AW:0]   r_rd_ptr;

    logic            w_is_e0;
    logic            w_is_f0;
    logic            w_ext;
    logic            w_brk;
    logic            w_evt;
    logic            w_is_shift;
    logic            w_is_caps;
    logic            w_repeat;
    logic            w_push_req;
    logic [10:0]     w_ev_word;
    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;

    assign w_is_e0 = (i_byte_data == 8'hE0);
    assign w_is_f0 = (i_byte_data == 8'hF0);
    assign w_ext   = (r_state == c_EXT) || (r_state == c_EXT_BRK);
    assign w_brk   = (r_state == c_BRK) || (r_state == c_EXT_BRK);
    // Any non-prefix byte closes the current sequence, whatever the state.
    assign w_evt   = i_byte_valid && !i_frame_err && !w_is_e0 && !w_is_f0;

    always_comb begin
        w_state_nxt = r_state;
        if (i_frame_err) begin
            w_state_nxt = c_IDLE;
        end else if (i_byte_valid) begin
            case (r_state)
                c_IDLE: begin
                    if (w_is_e0)      w_state_nxt = c_EXT;
                    else if (w_is_f0) w_state_nxt = c_BRK;
                    else              w_state_nxt = c_IDLE;
                end
                c_EXT: begin
                    if (w_is_f0)      w_state_nxt = c_EXT_BRK;
                    else if (w_is_e0) w_state_nxt = c_EXT;
                    else              w_state_nxt = c_IDLE;
                end
                default: begin
                    if (!w_is_e0 && !w_is_f0) w_state_nxt = c_IDLE;
                end
            endcase
        end
    end

    assign w_is_shift = !w_ext && ((i_byte_data == 8'h12) || (i_byte_data == 8'h59));
    assign w_is_caps  = !w_ext && (i_byte_data == 8'h58);
    assign w_repeat   = (REPEAT_EN == 0) && (i_byte_data == r_held);
    assign w_push_req = w_evt && !w_is_shift && !w_is_caps &&
                        (w_brk ? (BREAK_EN != 0) : !w_repeat);
    assign w_ev_word  = {r_shift ^ r_caps, w_ext, w_brk, i_byte_data};

    // Extra MSB on the pointers tells a full FIFO from an empty one.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = ((r_wr_ptr ^ r_rd_ptr) == {1'b1, {c_AW{1'b0}}});
    assign w_pop   = !w_empty && i_ev_ready;
    assign w_push  = w_push_req && (!w_full || w_pop);
    assign w_drop  = w_push_req && !w_push;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= c_IDLE;
            r_held    <= 8'h00;
            r_shift   <= 1'b0;
            r_caps    <= 1'b0;
            r_ovf     <= 1'b0;
            r_err_cnt <= 8'h00;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (i_frame_err && (r_err_cnt != 8'hFF))
                r_err_cnt <= r_err_cnt + 8'd1;
            if (w_evt) begin
                if (w_is_shift) begin
                    r_shift <= !w_brk;
                end else if (w_is_caps) begin
                    if (w_brk) begin
                        r_held <= 8'h00;
                    end else begin
                        if (r_held != 8'h58) r_caps <= !r_caps;
                        r_held <= 8'h58;
                    end
                end else if (w_brk) begin
                    if (i_byte_data == r_held) r_held <= 8'h00;
                end else if (!w_repeat) begin
                    r_held <= i_byte_data;
                end
            end
            if (w_push) r_wr_ptr <= r_wr_ptr + (c_AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (c_AW+1)'(1);
            if (w_drop)
                r_ovf <= 1'b1;
            else if (i_ovf_clr)
                r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[c_AW-1:0]] <= w_ev_word;
    end

    assign o_ev_valid = !w_empty;
    assign o_ev_data  = w_empty ? 11'd0 : r_mem[r_rd_ptr[c_AW-1:0]];
    assign o_shift    = r_shift;
    assign o_caps     = r_caps;
    assign o_ovf      = r_ovf;
    assign o_err_cnt  = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_key_ctrl
// Brief    : Scoreboard bench for ps2_key_ctrl; two configurations share stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_key_ctrl;

    localparam int D0 = 8, B0 = 1, R0 = 0;
    localparam int D1 = 4, B1 = 0, R1 = 1;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        frame_err = 1'b0;
    logic        ev_ready = 1'b0;
    logic        ovf_clr = 1'b0;

    logic        v0, v1, s0, s1, c0, c1, o0, o1;
    logic [10:0] d0, d1;
    logic [7:0]  e0, e1;

    always #5 clk = ~clk;

    ps2_key_ctrl #(.DEPTH(D0), .BREAK_EN(B0), .REPEAT_EN(R0)) u0 (
        .clk(clk), .resetn(resetn), .i_byte_valid(byte_valid), .i_byte_data(byte_data),
        .i_frame_err(frame_err), .o_ev_valid(v0), .i_ev_ready(ev_ready), .o_ev_data(d0),
        .o_shift(s0), .o_caps(c0), .o_ovf(o0), .i_ovf_clr(ovf_clr), .o_err_cnt(e0));

    ps2_key_ctrl #(.DEPTH(D1), .BREAK_EN(B1), .REPEAT_EN(R1)) u1 (
        .clk(clk), .resetn(resetn), .i_byte_valid(byte_valid), .i_byte_data(byte_data),
        .i_frame_err(frame_err), .o_ev_valid(v1), .i_ev_ready(ev_ready), .o_ev_data(d1),
        .o_shift(s1), .o_caps(c1), .o_ovf(o1), .i_ovf_clr(ovf_clr), .o_err_cnt(e1));

    int checks = 0;
    int failures = 0;
    bit started = 1'b0;

    // Reference state: pending prefix flags, key state, expected FIFO contents.
    bit          m_ext [2];
    bit          m_brk [2];
    bit          m_shift [2];
    bit          m_caps [2];
    bit          m_ovf [2];
    logic [7:0]  m_held [2];
    int          m_err [2];
    int          m_occ [2];
    logic [10:0] q0 [$];
    logic [10:0] q1 [$];

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d actual=%0h expected=%0h t=%0t", nm, k, act, exp, $time);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int depth = (k == 0) ? D0 : D1;
            bit brk_en = (k == 0) ? (B0 != 0) : (B1 != 0);
            bit rep_en = (k == 0) ? (R0 != 0) : (R1 != 0);
            bit pop, req, acc;
            logic [10:0] word;
            req = 1'b0;
            word = '0;
            if (!resetn) begin
                m_ext[k] = 0; m_brk[k] = 0; m_shift[k] = 0; m_caps[k] = 0;
                m_ovf[k] = 0; m_held[k] = 8'h00; m_err[k] = 0; m_occ[k] = 0;
                if (k == 0) q0.delete(); else q1.delete();
            end else begin
                pop = (m_occ[k] > 0) && ev_ready;
                if (frame_err) begin
                    m_ext[k] = 0; m_brk[k] = 0;
                    if (m_err[k] < 255) m_err[k]++;
                end else if (byte_valid) begin
                    if (byte_data == 8'hE0) begin
                        if (!m_brk[k]) m_ext[k] = 1;
                    end else if (byte_data == 8'hF0) begin
                        m_brk[k] = 1;
                    end else begin
                        word = {m_shift[k] ^ m_caps[k], m_ext[k], m_brk[k], byte_data};
                        if (!m_ext[k] && (byte_data == 8'h12 || byte_data == 8'h59)) begin
                            m_shift[k] = !m_brk[k];
                        end else if (!m_ext[k] && byte_data == 8'h58) begin
                            if (m_brk[k]) m_held[k] = 8'h00;
                            else begin
                                if (m_held[k] != 8'h58) m_caps[k] = !m_caps[k];
                                m_held[k] = 8'h58;
                            end
                        end else if (m_brk[k]) begin
                            if (byte_data == m_held[k]) m_held[k] = 8'h00;
                            req = brk_en;
                        end else if (!(!rep_en && byte_data == m_held[k])) begin
                            m_held[k] = byte_data;
                            req = 1'b1;
                        end
                        m_ext[k] = 0; m_brk[k] = 0;
                    end
                end
                acc = req && (m_occ[k] < depth || pop);
                if (acc) begin
                    if (k == 0) q0.push_back(word); else q1.push_back(word);
                end
                m_occ[k] = m_occ[k] + (acc ? 1 : 0) - (pop ? 1 : 0);
                if (req && !acc) m_ovf[k] = 1;
                else if (ovf_clr) m_ovf[k] = 0;
            end
        end
    endtask

    // Advance one edge and bring the model to the post-edge state.
    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        started = 1'b1;
        byte_valid = 1'b0;
        frame_err = 1'b0;
        ovf_clr = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data = b;
        tick();
        tick();
    endtask

    task automatic mon(input int k, input logic v, input logic [10:0] d, input logic s,
                       input logic c, input logic o, input logic [7:0] e);
        int sz;
        logic [10:0] head;
        sz = (k == 0) ? q0.size() : q1.size();
        chk("ev_valid", k, 32'(v), 32'(m_occ[k] > 0));
        chk("shift", k, 32'(s), 32'(m_shift[k]));
        chk("caps", k, 32'(c), 32'(m_caps[k]));
        chk("ovf", k, 32'(o), 32'(m_ovf[k]));
        chk("err_cnt", k, 32'(e), 32'(m_err[k]));
        if (!v) begin
            chk("ev_data_empty", k, 32'(d), 32'd0);
        end else if (sz > 0) begin
            head = (k == 0) ? q0[0] : q1[0];
            chk("ev_data", k, 32'(d), 32'(head));
            if (ev_ready && resetn) begin
                if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            mon(0, v0, d0, s0, c0, o0, e0);
            mon(1, v1, d1, s1, c1, o1, e1);
        end
    end

    logic [7:0] pool [10] = '{8'h12, 8'h59, 8'h58, 8'h1C, 8'h1B, 8'h23, 8'h75, 8'hE0, 8'hF0, 8'h4D};
    logic [7:0] distinct [10] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44, 8'h4D};

    task automatic do_reset();
        resetn = 1'b0;
        tick(); tick();
        resetn = 1'b1;
    endtask

    initial begin
        ev_ready = 1'b1;
        do_reset();
        send(8'h1C); send(8'hF0); send(8'h1C);
        send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C);
        send(8'hF0); send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C);
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        send(8'h58); send(8'h58); send(8'hF0); send(8'h58); send(8'h58);
        send(8'h58); send(8'hF0); send(8'h58);
        send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
        send(8'hE0);
        frame_err = 1'b1; tick();
        send(8'h75);
        byte_valid = 1'b1; byte_data = 8'h33; frame_err = 1'b1; tick(); tick();
        send(8'hF0);
        do_reset();
        send(8'h1C);
        for (int i = 0; i < 4; i++) tick();
        // Fill both FIFOs past capacity, then pop and push on the same edge.
        do_reset();
        ev_ready = 1'b0;
        for (int i = 0; i < 9; i++) send(distinct[i]);
        ev_ready = 1'b1;
        byte_valid = 1'b1; byte_data = distinct[9]; tick();
        for (int i = 0; i < 12; i++) tick();
        ovf_clr = 1'b1; tick();
        for (int i = 0; i < 3000; i++) begin
            resetn = ($urandom_range(0, 599) != 0);
            byte_valid = ($urandom_range(0, 2) == 0);
            byte_data = pool[$urandom_range(0, 9)];
            frame_err = ($urandom_range(0, 39) == 0);
            ovf_clr = ($urandom_range(0, 29) == 0);
            ev_ready = (i % 600 < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
            @(posedge clk);
            #1;
            model_step();
        end
        resetn = 1'b1;
        byte_valid = 1'b0;
        frame_err = 1'b0;
        ovf_clr = 1'b0;
        ev_ready = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        chk("drain_q", 0, 32'(q0.size()), 32'd0);
        chk("drain_q", 1, 32'(q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
